// File: rtl/led_status_pkg.sv
// Shared definitions for the multi-channel LED status indicator.
// Holds the mode encodings, the channel FSM state encoding and the pattern constants.
package led_status_pkg;

    localparam int PHASE_W   = 4;
    localparam int GAP_TICKS = 8;

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_SLOW  = 3'd2,
        MODE_FAST  = 3'd3,
        MODE_BURST = 3'd4,
        MODE_FLASH = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } chan_state_e;

    // State a channel FSM takes when its mode is (re)entered.
    function automatic chan_state_e entry_state(input logic [2:0] mode);
        if (mode == MODE_BURST) begin
            return ST_ON;
        end else begin
            return ST_IDLE;
        end
    endfunction

    // Number of blinks per burst; a programmed count of 0 means a single blink.
    function automatic logic [2:0] burst_len(input logic [2:0] cnt);
        if (cnt == 3'd0) begin
            return 3'd1;
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/led_status_chan.sv
// One LED channel: mode/count (and duty) registers, the BURST/FLASH FSM and the LED output flop.
// Optional brightness gating is compiled in with LED_STATUS_PWM_EN.
module led_status_chan
    import led_status_pkg::*;
#(
    parameter int         FLASH_TICKS = 2,
    parameter logic [2:0] RST_MODE    = 3'd2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       tick_in,
    input  logic       slow_in,
    input  logic       fast_in,
    input  logic       event_in,
    input  logic       wr_in,
    input  logic [2:0] mode_in,
    input  logic [2:0] cnt_in,
`ifdef LED_STATUS_PWM_EN
    input  logic [3:0] duty_in,
    input  logic [3:0] pwm_cnt_in,
`endif
    output logic       led_out
);

    localparam int              CD_W    = $clog2(FLASH_TICKS + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FLASH_TICKS);

    logic [2:0]      mode_q, mode_d;
    logic [2:0]      cnt_q, cnt_d;
    chan_state_e     state_q, state_d;
    logic [2:0]      blink_q, blink_d;
    logic [2:0]      gap_q, gap_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic            led_q, led_d;
    logic            pattern_s;
`ifdef LED_STATUS_PWM_EN
    logic [3:0]      duty_q, duty_d;
`endif

    // Next-state logic: a write reinitialises the channel and takes priority over tick and event.
    always_comb begin
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        blink_d = blink_q;
        gap_d   = gap_q;
        cd_d    = cd_q;
`ifdef LED_STATUS_PWM_EN
        duty_d  = duty_q;
`endif
        if (wr_in) begin
            mode_d  = mode_in;
            cnt_d   = cnt_in;
            state_d = entry_state(mode_in);
            blink_d = 3'd0;
            gap_d   = 3'd0;
            cd_d    = '0;
`ifdef LED_STATUS_PWM_EN
            duty_d  = duty_in;
`endif
        end else begin
            case (mode_q)
                MODE_BURST: begin
                    if (tick_in) begin
                        case (state_q)
                            ST_ON: begin
                                if (({1'b0, blink_q} + 4'd1) >= {1'b0, burst_len(cnt_q)}) begin
                                    state_d = ST_GAP;
                                    blink_d = 3'd0;
                                    gap_d   = 3'd0;
                                end else begin
                                    state_d = ST_OFF;
                                    blink_d = blink_q + 3'd1;
                                end
                            end
                            ST_OFF: begin
                                state_d = ST_ON;
                            end
                            ST_GAP: begin
                                if (gap_q == 3'(GAP_TICKS - 1)) begin
                                    state_d = ST_ON;
                                    gap_d   = 3'd0;
                                end else begin
                                    gap_d = gap_q + 3'd1;
                                end
                            end
                            default: begin
                                state_d = ST_ON;
                            end
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end
                MODE_FLASH: begin
                    // An event reloads the countdown even when a tick would end ON.
                    if (event_in) begin
                        state_d = ST_ON;
                        cd_d    = CD_LOAD;
                    end else if (tick_in && (state_q == ST_ON)) begin
                        if (cd_q <= CD_W'(1)) begin
                            state_d = ST_IDLE;
                            cd_d    = '0;
                        end else begin
                            cd_d = cd_q - CD_W'(1);
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Pattern selection from the current mode and state; the result is registered below.
    always_comb begin
        case (mode_q)
            MODE_OFF:   pattern_s = 1'b0;
            MODE_ON:    pattern_s = 1'b1;
            MODE_SLOW:  pattern_s = slow_in;
            MODE_FAST:  pattern_s = fast_in;
            MODE_BURST: pattern_s = (state_q == ST_ON);
            MODE_FLASH: pattern_s = (state_q == ST_ON);
            default:    pattern_s = 1'b0;
        endcase
`ifdef LED_STATUS_PWM_EN
        led_d = pattern_s & (pwm_cnt_in <= duty_q);
`else
        led_d = pattern_s;
`endif
    end

    // Channel registers with asynchronous reset into the reset mode's entry state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mode_q  <= RST_MODE;
            cnt_q   <= 3'd1;
            state_q <= entry_state(RST_MODE);
            blink_q <= 3'd0;
            gap_q   <= 3'd0;
            cd_q    <= '0;
            led_q   <= 1'b0;
`ifdef LED_STATUS_PWM_EN
            duty_q  <= 4'd15;
`endif
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            blink_q <= blink_d;
            gap_q   <= gap_d;
            cd_q    <= cd_d;
            led_q   <= led_d;
`ifdef LED_STATUS_PWM_EN
            duty_q  <= duty_d;
`endif
        end
    end

    assign led_out = led_q;

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel LED status controller: shared prescaler, phase counter and channel array.
// Define LED_STATUS_PWM_EN to add per-channel brightness (cfg_duty_in and a shared PWM counter).
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int PRESCALE_W  = 22,
    parameter int RST_MODE    = 2,
    parameter int FLASH_TICKS = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                cfg_wr_in,
    input  logic [2:0]          cfg_ch_in,
    input  logic [2:0]          cfg_mode_in,
    input  logic [2:0]          cfg_cnt_in,
`ifdef LED_STATUS_PWM_EN
    input  logic [3:0]          cfg_duty_in,
`endif
    input  logic [CHANNELS-1:0] event_in,
    output logic                tick_out,
    output logic [CHANNELS-1:0] led_out
);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic                  tick_s;
    logic [CHANNELS-1:0]   ch_wr_s;
`ifdef LED_STATUS_PWM_EN
    logic [3:0]            pwm_q, pwm_d;
`endif

    // The tick marks the cycle in which the prescaler is about to wrap to zero.
    assign tick_s   = (presc_q == {PRESCALE_W{1'b1}});
    assign tick_out = tick_s;

    // Free-running prescaler, tick-driven phase counter and per-clock PWM counter.
    always_comb begin
        presc_d = presc_q + PRESCALE_W'(1);
        if (tick_s) begin
            phase_d = phase_q + PHASE_W'(1);
        end else begin
            phase_d = phase_q;
        end
`ifdef LED_STATUS_PWM_EN
        pwm_d = pwm_q + 4'd1;
`endif
    end

    // Shared timebase registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            presc_q <= '0;
            phase_q <= '0;
`ifdef LED_STATUS_PWM_EN
            pwm_q   <= 4'd0;
`endif
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
`ifdef LED_STATUS_PWM_EN
            pwm_q   <= pwm_d;
`endif
        end
    end

    // Write decode: channel numbers at or above CHANNELS match no instance and are dropped.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign ch_wr_s[gi] = cfg_wr_in && (cfg_ch_in == 3'(gi));

        led_status_chan #(
            .FLASH_TICKS (FLASH_TICKS),
            .RST_MODE    (3'(RST_MODE))
        ) u_chan (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .tick_in    (tick_s),
            .slow_in    (phase_q[PHASE_W-1]),
            .fast_in    (phase_q[1]),
            .event_in   (event_in[gi]),
            .wr_in      (ch_wr_s[gi]),
            .mode_in    (cfg_mode_in),
            .cnt_in     (cfg_cnt_in),
`ifdef LED_STATUS_PWM_EN
            .duty_in    (cfg_duty_in),
            .pwm_cnt_in (pwm_q),
`endif
            .led_out    (led_out[gi])
        );
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench for led_status_ctrl: the driver steps a behavioural model every cycle and
// queues the expected outputs; a monitor pops and compares them one clock edge later.
module tb_led_status_ctrl;

    localparam int CH = 4;
    localparam int PW = 4;
    localparam int RM = 2;
    localparam int FT = 2;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          cfg_wr_in = 1'b0;
    logic [2:0]    cfg_ch_in = 3'd0;
    logic [2:0]    cfg_mode_in = 3'd0;
    logic [2:0]    cfg_cnt_in = 3'd0;
`ifdef LED_STATUS_PWM_EN
    logic [3:0]    cfg_duty_in = 4'd15;
`endif
    logic [CH-1:0] event_in = '0;
    logic          tick_out;
    logic [CH-1:0] led_out;

    always #5 clk_in = ~clk_in;

    led_status_ctrl #(
        .CHANNELS    (CH),
        .PRESCALE_W  (PW),
        .RST_MODE    (RM),
        .FLASH_TICKS (FT)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .cfg_wr_in   (cfg_wr_in),
        .cfg_ch_in   (cfg_ch_in),
        .cfg_mode_in (cfg_mode_in),
        .cfg_cnt_in  (cfg_cnt_in),
`ifdef LED_STATUS_PWM_EN
        .cfg_duty_in (cfg_duty_in),
`endif
        .event_in    (event_in),
        .tick_out    (tick_out),
        .led_out     (led_out)
    );

    typedef struct packed {
        logic [CH-1:0] led;
        logic          tick;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: timebase as cycle/tick counts, channels as ticks since mode entry.
    int m_presc, m_phase, m_pwm;
    int m_mode[CH], m_cnt[CH], m_duty[CH], m_ticks[CH], m_flash[CH];

    function automatic logic model_led(input int c);
        logic on;
        int   n, p;
        case (m_mode[c])
            1: on = 1'b1;
            2: on = (m_phase >= 8);
            3: on = ((m_phase / 2) % 2) == 1;
            4: begin
                n  = (m_cnt[c] == 0) ? 1 : m_cnt[c];
                p  = m_ticks[c] % (2 * n - 1 + 8);
                on = (p < 2 * n - 1) && ((p % 2) == 0);
            end
            5: on = (m_flash[c] > 0);
            default: on = 1'b0;
        endcase
`ifdef LED_STATUS_PWM_EN
        on = on && (m_pwm <= m_duty[c]);
`endif
        return on;
    endfunction

    task automatic model_step(input logic r, input logic wr, input int ch, input int mode,
                              input int cnt, input int duty, input logic [CH-1:0] ev);
        exp_t e;
        logic tick;
        if (r) begin
            m_presc = 0;
            m_phase = 0;
            m_pwm   = 0;
            for (int c = 0; c < CH; c++) begin
                m_mode[c]  = RM;
                m_cnt[c]   = 1;
                m_duty[c]  = 15;
                m_ticks[c] = 0;
                m_flash[c] = 0;
            end
            e.led  = '0;
            e.tick = 1'b0;
        end else begin
            tick = (m_presc == 15);
            for (int c = 0; c < CH; c++) begin
                e.led[c] = model_led(c);
            end
            for (int c = 0; c < CH; c++) begin
                if (wr && (ch == c)) begin
                    m_mode[c]  = mode;
                    m_cnt[c]   = cnt;
                    m_duty[c]  = duty;
                    m_ticks[c] = 0;
                    m_flash[c] = 0;
                end else begin
                    if (m_mode[c] == 5) begin
                        if (ev[c]) m_flash[c] = FT;
                        else if (tick && (m_flash[c] > 0)) m_flash[c] = m_flash[c] - 1;
                    end
                    if (tick) m_ticks[c] = m_ticks[c] + 1;
                end
            end
            m_presc = (m_presc + 1) % 16;
            m_pwm   = (m_pwm + 1) % 16;
            if (tick) m_phase = (m_phase + 1) % 16;
            e.tick = (m_presc == 15);
        end
        last_exp = e;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of stimulus at the falling edge and queue the outcome of the next rising edge.
    task automatic drive(input logic r, input logic wr, input int ch, input int mode,
                         input int cnt, input int duty, input logic [CH-1:0] ev);
        @(negedge clk_in);
        rst_in      = r;
        cfg_wr_in   = wr;
        cfg_ch_in   = 3'(ch);
        cfg_mode_in = 3'(mode);
        cfg_cnt_in  = 3'(cnt);
`ifdef LED_STATUS_PWM_EN
        cfg_duty_in = 4'(duty);
`endif
        event_in    = ev;
        model_step(r, wr, ch, mode, cnt, duty, ev);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 15, '0);
    endtask

    task automatic cfg(input int ch, input int mode, input int cnt, input int duty);
        drive(1'b0, 1'b1, ch, mode, cnt, duty, '0);
    endtask

    task automatic pulse(input logic [CH-1:0] ev);
        drive(1'b0, 1'b0, 0, 0, 0, 15, ev);
    endtask

    // Idle until the next driven cycle is one in which the prescaler wraps.
    task automatic align_tick();
        for (int i = 0; i < 20 && m_presc != 15; i++) idle(1);
    endtask

    // Assert reset between clock edges and confirm the outputs drop without waiting for a clock.
    task automatic async_reset();
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        checks++;
        if (led_out !== '0 || tick_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got led=%b tick=%b want led=%b tick=0", led_out, tick_out, {CH{1'b0}});
        end
    endtask

    // Monitor: one expected entry per rising edge, compared just after the edge.
    initial begin
        exp_t e;
        @(negedge clk_in);
        forever begin
            @(posedge clk_in);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at %0t got led=%b want an expected entry", $time, led_out);
            end else begin
                e = exp_q.pop_front();
                if (led_out !== e.led || tick_out !== e.tick) begin
                    errors++;
                    $display("FAIL led_tick at %0t got led=%b tick=%b want led=%b tick=%b",
                             $time, led_out, tick_out, e.led, e.tick);
                end
            end
        end
    end

    initial begin
        int wr_cnt;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 0, 0, 0, 15, '0);
        idle(300);                          // reset pattern: all channels SLOW in lockstep
        cfg(1, 4, 3, 15);                   // ch1 BURST of 3
        idle(600);
        cfg(1, 4, 0, 15);                   // cnt 0 -> single blink per burst
        idle(300);
        cfg(2, 5, 0, 15);                   // ch2 FLASH
        idle(5);
        pulse(4'b0100);
        idle(60);
        pulse(4'b0100);
        idle(16);
        pulse(4'b0100);                     // retrigger one tick later
        idle(80);
        pulse(4'b0001);                     // event on a SLOW channel is ignored
        idle(20);
        cfg(5, 1, 0, 15);                   // out-of-range channel
        idle(40);
        cfg(3, 3, 0, 15);                   // ch3 FAST
        align_tick();
        cfg(0, 4, 2, 15);                   // write coincident with tick on ch0
        idle(100);
        pulse(4'b0100);
        align_tick();
        idle(1);
        align_tick();
        pulse(4'b0100);                     // event on the tick that would end ON
        idle(60);
        cfg(1, 4, 3, 15);
        for (int i = 0; i < 400 && !last_exp.led[1]; i++) idle(1);
        async_reset();                      // mid-burst, while ch1 is lit
        drive(1'b1, 1'b0, 0, 0, 0, 15, '0);
        drive(1'b1, 1'b0, 0, 0, 0, 15, '0);
        idle(300);
`ifdef LED_STATUS_PWM_EN
        cfg(0, 1, 0, 3);
        idle(64);
        cfg(0, 1, 0, 15);
        idle(32);
`endif
        wr_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            logic          wr;
            logic [CH-1:0] ev;
            wr = ($urandom_range(0, 49) == 0);
            ev = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
            if (wr) wr_cnt++;
`ifdef LED_STATUS_PWM_EN
            drive(1'b0, wr, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 15), ev);
`else
            drive(1'b0, wr, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  15, ev);
`endif
        end
        @(posedge clk_in);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
